// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state encodings and round-robin helper for rr_clr_stage_sched
// Purpose: status FSM state type with explicit encodings, pointer wrap helper.
// Ports: none (package).
package sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BUSY  = ST_BUSY,
    STALL = ST_STALL
  } state_t;

  // Index following idx in a ring of n entries.
  function automatic int rr_wrap(input int idx, input int n);
    if (idx + 1 >= n) return 0;
    else return idx + 1;
  endfunction

endpackage

// File: rtl/clr_reg_stage.sv
// rtl/clr_reg_stage.sv - clearable register stage with valid and id sideband
// Purpose: y <= ct ? 0 : x when enabled; valid and id travel alongside.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_en         load enable; all fields hold when low
//   i_ct         clear term: loads zero instead of i_x
//   i_vld, i_id  sideband captured with the data
//   i_x          data input
//   o_y, o_vld, o_id  registered outputs
module clr_reg_stage
  import sched_pkg::*;
#(
  parameter int DW  = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_ct,
  input  logic           i_vld,
  input  logic [IDW-1:0] i_id,
  input  logic [DW-1:0]  i_x,
  output logic [DW-1:0]  o_y,
  output logic           o_vld,
  output logic [IDW-1:0] o_id
);

  logic [DW-1:0]  r_y;
  logic           r_vld;
  logic [IDW-1:0] r_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y   <= '0;
      r_vld <= 1'b0;
      r_id  <= '0;
    end else if (i_en) begin
      r_y   <= i_ct ? '0 : i_x;
      r_vld <= i_vld;
      r_id  <= i_id;
    end
  end

  assign o_y   = r_y;
  assign o_vld = r_vld;
  assign o_id  = r_id;

endmodule

// File: rtl/rr_clr_stage_sched.sv
// rtl/rr_clr_stage_sched.sv - round-robin scheduler over a shared clearable stage and +1 output stage
// Purpose: grant one of N_REQ requesters per cycle, push its payload through a
//   clearable register and a +1 stage, tag results with the requester id.
// Ports:
//   clk, rst     clock, synchronous active-high reset (beats flush)
//   flush        discard everything in flight, suppress this cycle's grant
//   req          per-requester request level, held until gnt
//   req_data     payloads, slice i = [i*DW +: DW]
//   gnt          one-hot accept pulse
//   out_valid, out_data, out_id  result (payload + 1) and producing requester
//   out_ready    consumer accept
//   busy         status FSM not idle
module rr_clr_stage_sched
  import sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DW-1:0]     req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    out_valid,
  output logic [DW-1:0]           out_data,
  output logic [$clog2(N_REQ)-1:0] out_id,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] r_rr_ptr;
  logic [DW-1:0]  r_out_data;
  logic           r_out_valid;
  logic [IDW-1:0] r_out_id;
  state_t         r_state;
  state_t         w_state_nxt;

  logic           w_adv;
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic           w_granted;
  logic [DW-1:0]  w_s1_data;
  logic           w_s1_valid;
  logic [IDW-1:0] w_s1_id;
  logic           w_s1_valid_nxt;
  logic           w_out_valid_nxt;

  // The pipeline only moves when the output slot is free or being drained.
  assign w_adv = !r_out_valid || out_ready;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  assign w_granted = w_adv && w_found && !flush && !rst;

  always_comb begin
    gnt = '0;
    if (w_granted) gnt[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rr_ptr <= '0;
    else if (w_granted) r_rr_ptr <= IDW'(rr_wrap(int'(w_win), N_REQ));
  end

  // Stage 1 also loads under flush so an in-flight item is dropped even while
  // the output is stalled; ct forces zero data on every non-grant load.
  clr_reg_stage #(.DW(DW), .IDW(IDW)) u_stage1 (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_adv || flush),
    .i_ct  (!w_granted),
    .i_vld (w_granted),
    .i_id  (w_win),
    .i_x   (req_data[w_win*DW +: DW]),
    .o_y   (w_s1_data),
    .o_vld (w_s1_valid),
    .o_id  (w_s1_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
    end else if (w_adv) begin
      r_out_data  <= w_s1_data + DW'(1);
      r_out_valid <= w_s1_valid && !flush;
      r_out_id    <= w_s1_id;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

  // Valid bits as they will be after this edge, used to detect draining.
  assign w_s1_valid_nxt  = (w_adv || flush) ? w_granted : w_s1_valid;
  assign w_out_valid_nxt = w_adv ? (w_s1_valid && !flush) : (r_out_valid && !flush);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_granted) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (flush) w_state_nxt = IDLE;
        else if (r_out_valid && !out_ready) w_state_nxt = STALL;
        else if (!w_s1_valid_nxt && !w_out_valid_nxt) w_state_nxt = IDLE;
      end
      STALL: begin
        if (flush) w_state_nxt = IDLE;
        else if (out_ready) w_state_nxt = BUSY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_rr_clr_stage_sched.sv
// tb/tb_rr_clr_stage_sched.sv - self-checking bench for rr_clr_stage_sched
module tb_rr_clr_stage_sched;
  import sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int DW    = 8;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    gnt;
  logic                out_valid;
  logic [DW-1:0]       out_data;
  logic [IDW-1:0]      out_id;
  logic                out_ready = 1'b1;
  logic                busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  rr_clr_stage_sched #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int id, input logic [DW-1:0] payload);
    exp_t e;
    e.id   = IDW'(id);
    e.data = payload + 8'h01;
    return e;
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected out_id=%0d out_data=%h expected=none", out_id, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_id !== mon_e.id || out_data !== mon_e.data) begin
          failures++;
          $display("FAIL sb_result got id=%0d data=%h expected id=%0d data=%h",
                   out_id, out_data, mon_e.id, mon_e.data);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    next_cycle();
    req = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy !== 1'b0) && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_%s pending=%0d busy=%b expected pending=0 busy=0", name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req = '1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b expected=0000", gnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h expected=00", out_data); end
    checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d expected=0", out_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
    next_cycle();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_all_req();
    logic [N_REQ-1:0] eg;
    for (int i = 0; i < N_REQ; i++) set_data(i, 8'(8'h20 + i));
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req = '1;
      @(negedge clk);
      eg = 4'(1 << (k % 4));
      checks++;
      if (gnt !== eg) begin failures++; $display("FAIL allreq_gnt k=%0d got=%b expected=%b", k, gnt, eg); end
      sb.push_back(mk(k % 4, 8'(8'h20 + (k % 4))));
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_id !== IDW'(k - 2)) begin
          failures++;
          $display("FAIL allreq_out_id k=%0d got valid=%b id=%0d expected valid=1 id=%0d", k, out_valid, out_id, k - 2);
        end
      end
    end
    drain("allreq");
  endtask

  task automatic test_single();
    next_cycle();
    req = 4'b0001;
    set_data(0, 8'h10);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b expected=0001", gnt); end
    sb.push_back(mk(0, 8'h10));
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0) begin failures++; $display("FAIL single_t1 got gnt=%b valid=%b expected gnt=0000 valid=0", gnt, out_valid); end
    next_cycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_id !== 2'd0) begin failures++; $display("FAIL single_t2 got valid=%b data=%h id=%0d expected valid=1 data=11 id=0", out_valid, out_data, out_id); end
    next_cycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h01) begin failures++; $display("FAIL single_idle got valid=%b data=%h expected valid=0 data=01", out_valid, out_data); end
    drain("single");
  endtask

  task automatic test_wrap();
    next_cycle();
    req = 4'b0100;
    set_data(2, 8'hFF);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL wrap_gnt got=%b expected=0100", gnt); end
    sb.push_back(mk(2, 8'hFF));
    next_cycle();
    req = '0;
    next_cycle();
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || out_id !== 2'd2) begin failures++; $display("FAIL wrap_out got valid=%b data=%h id=%0d expected valid=1 data=00 id=2", out_valid, out_data, out_id); end
    drain("wrap");
  endtask

  task automatic test_backpressure();
    next_cycle();
    req = 4'b1000;
    set_data(3, 8'h30);
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL bp_gnt0 got=%b expected=1000", gnt); end
    sb.push_back(mk(3, 8'h30));
    next_cycle();
    req = 4'b0001;
    set_data(0, 8'h40);
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL bp_gnt1 got=%b expected=0001", gnt); end
    sb.push_back(mk(0, 8'h40));
    next_cycle();
    req = 4'b0010;
    set_data(1, 8'h50);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h31 || out_id !== 2'd3) begin
        failures++;
        $display("FAIL bp_hold i=%0d got gnt=%b valid=%b data=%h id=%0d expected gnt=0000 valid=1 data=31 id=3", i, gnt, out_valid, out_data, out_id);
      end
      if (i >= 1) begin
        checks++;
        if (dut.r_state !== STALL || busy !== 1'b1) begin failures++; $display("FAIL bp_state i=%0d got state=%0d busy=%b expected state=%0d busy=1", i, dut.r_state, busy, ST_STALL); end
      end
      if (i < 2) next_cycle();
    end
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bp_resume_gnt got=%b expected=0010", gnt); end
    sb.push_back(mk(1, 8'h50));
    next_cycle();
    req = '0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h41 || out_id !== 2'd0) begin failures++; $display("FAIL bp_next got valid=%b data=%h id=%0d expected valid=1 data=41 id=0", out_valid, out_data, out_id); end
    drain("bp");
  endtask

  task automatic test_flush();
    next_cycle();
    req = 4'b0100;
    set_data(2, 8'h60);
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL flush_gnt0 got=%b expected=0100", gnt); end
    sb.push_back(mk(2, 8'h60));
    next_cycle();
    req = 4'b1000;
    set_data(3, 8'h70);
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL flush_gnt1 got=%b expected=1000", gnt); end
    sb.push_back(mk(3, 8'h70));
    next_cycle();
    flush = 1'b1;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || out_valid !== 1'b1) begin failures++; $display("FAIL flush_cycle got gnt=%b valid=%b expected gnt=0000 valid=1", gnt, out_valid); end
    sb.delete();
    next_cycle();
    flush = 1'b0;
    req = 4'b1111;
    set_data(0, 8'h80);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_after got valid=%b busy=%b expected valid=0 busy=0", out_valid, busy); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL flush_ptr got=%b expected=0001", gnt); end
    sb.push_back(mk(0, 8'h80));
    drain("flush");
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < N_REQ; i++) set_data(i, 8'(8'h90 + i));
    next_cycle();
    req = 4'b1111;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rstmid_gnt0 got=%b expected=0010", gnt); end
    sb.push_back(mk(1, 8'h91));
    next_cycle();
    @(negedge clk);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rstmid_gnt1 got=%b expected=0100", gnt); end
    sb.push_back(mk(2, 8'h92));
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rstmid_gnt_rst got=%b expected=0000", gnt); end
    sb.delete();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_id !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_outs got valid=%b data=%h id=%0d busy=%b expected all 0", out_valid, out_data, out_id, busy); end
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstmid_first_gnt got=%b expected=0001", gnt); end
    sb.push_back(mk(0, 8'h90));
    drain("rstmid");
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_wrap();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
